// File: rtl/pipelined_prefix_adder.sv
// Pipelined Brent-Kung adder/subtractor with a valid/ready handshake.
// Group P/G generation, a prefix tree for group carries, then group sums and flags.
module pipelined_prefix_adder #(
    parameter int WIDTH     = 64,
    parameter int GROUPSIZE = 8,
    parameter int STAGES    = 2,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int NG     = WIDTH / GROUPSIZE;
    localparam int LOG_NG = $clog2(NG);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c0;
        logic [NG-1:0]    gg;
        logic [NG-1:0]    gp;
        logic [TAG_W-1:0] tag;
    } pg_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [NG-1:0]    gc;
        logic             cout;
        logic [TAG_W-1:0] tag;
    } cy_t;

    logic              advance_s;
    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] feed_valid_s;
    pg_t               pg_s;
    pg_t               pg_q;
    cy_t               cy_s;
    cy_t               cy_q;
    logic              grp_g_s;
    logic              grp_p_s;
    logic [NG-1:0]     pfx_g_s;
    logic [NG-1:0]     pfx_p_s;
    logic [WIDTH-1:0]  sum_s;
    logic              carry_s;
    logic              ovf_s;
    logic              zero_s;

    // Global stall: the whole pipe moves only when the output slot can be vacated.
    assign advance_s = !valid_r[STAGES-1] || out_ready;
    assign in_ready  = advance_s;
    assign out_valid = valid_r[STAGES-1];

    // Valid bit each slot would take on an advance.
    always_comb begin
        feed_valid_s    = '0;
        feed_valid_s[0] = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            feed_valid_s[i] = valid_r[i-1];
        end
    end

    // Slot valid bits shift forward on every advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (advance_s) begin
            valid_r <= feed_valid_s;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Operand transform and per-group generate/propagate (ripple inside each group).
    always_comb begin
        pg_s     = '0;
        grp_g_s  = 1'b0;
        grp_p_s  = 1'b1;
        pg_s.a   = in_a;
        pg_s.b   = in_sub ? ~in_b : in_b;
        pg_s.c0  = in_sub ? 1'b1 : in_cin;
        pg_s.tag = in_tag;
        for (int g = 0; g < NG; g++) begin
            grp_g_s = 1'b0;
            grp_p_s = 1'b1;
            for (int j = 0; j < GROUPSIZE; j++) begin
                grp_g_s = (pg_s.a[g*GROUPSIZE+j] & pg_s.b[g*GROUPSIZE+j]) |
                          ((pg_s.a[g*GROUPSIZE+j] ^ pg_s.b[g*GROUPSIZE+j]) & grp_g_s);
                grp_p_s = grp_p_s & (pg_s.a[g*GROUPSIZE+j] ^ pg_s.b[g*GROUPSIZE+j]);
            end
            pg_s.gg[g] = grp_g_s;
            pg_s.gp[g] = grp_p_s;
        end
    end

    generate
        if (STAGES == 3) begin : g_pg_reg
            // Optional slot after group P/G.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    pg_q <= '0;
                end else if (advance_s && feed_valid_s[0]) begin
                    pg_q <= pg_s;
                end else begin
                    pg_q <= pg_q;
                end
            end
        end else begin : g_pg_wire
            assign pg_q = pg_s;
        end
    endgenerate

    // Brent-Kung prefix over group (G,P): up-sweep then down-sweep, then apply c0.
    always_comb begin
        pfx_g_s = pg_q.gg;
        pfx_p_s = pg_q.gp;
        cy_s    = '0;
        for (int d = 0; d < LOG_NG; d++) begin
            for (int k = (2 << d) - 1; k < NG; k += (2 << d)) begin
                pfx_g_s[k] = pfx_g_s[k] | (pfx_p_s[k] & pfx_g_s[k-(1<<d)]);
                pfx_p_s[k] = pfx_p_s[k] & pfx_p_s[k-(1<<d)];
            end
        end
        for (int d = LOG_NG - 2; d >= 0; d--) begin
            for (int k = 3 * (1 << d) - 1; k < NG; k += (2 << d)) begin
                pfx_g_s[k] = pfx_g_s[k] | (pfx_p_s[k] & pfx_g_s[k-(1<<d)]);
                pfx_p_s[k] = pfx_p_s[k] & pfx_p_s[k-(1<<d)];
            end
        end
        cy_s.a     = pg_q.a;
        cy_s.b     = pg_q.b;
        cy_s.tag   = pg_q.tag;
        cy_s.gc[0] = pg_q.c0;
        for (int k = 1; k < NG; k++) begin
            cy_s.gc[k] = pfx_g_s[k-1] | (pfx_p_s[k-1] & pg_q.c0);
        end
        cy_s.cout = pfx_g_s[NG-1] | (pfx_p_s[NG-1] & pg_q.c0);
    end

    generate
        if (STAGES >= 2) begin : g_cy_reg
            // Optional slot after the prefix tree.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cy_q <= '0;
                end else if (advance_s && feed_valid_s[STAGES-2]) begin
                    cy_q <= cy_s;
                end else begin
                    cy_q <= cy_q;
                end
            end
        end else begin : g_cy_wire
            assign cy_q = cy_s;
        end
    endgenerate

    // Group sums from their carry-in, plus overflow and zero flags ahead of the output register.
    always_comb begin
        sum_s   = '0;
        carry_s = 1'b0;
        for (int g = 0; g < NG; g++) begin
            carry_s = cy_q.gc[g];
            for (int j = 0; j < GROUPSIZE; j++) begin
                sum_s[g*GROUPSIZE+j] = cy_q.a[g*GROUPSIZE+j] ^ cy_q.b[g*GROUPSIZE+j] ^ carry_s;
                carry_s = (cy_q.a[g*GROUPSIZE+j] & cy_q.b[g*GROUPSIZE+j]) |
                          ((cy_q.a[g*GROUPSIZE+j] ^ cy_q.b[g*GROUPSIZE+j]) & carry_s);
            end
        end
        ovf_s  = (cy_q.a[WIDTH-1] == cy_q.b[WIDTH-1]) && (sum_s[WIDTH-1] != cy_q.a[WIDTH-1]);
        zero_s = (sum_s == '0);
    end

    // Output slot; payload loads only when a valid result moves in, so held results stay stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
            out_tag  <= '0;
        end else if (advance_s && feed_valid_s[STAGES-1]) begin
            out_sum  <= sum_s;
            out_cout <= cy_q.cout;
            out_ovf  <= ovf_s;
            out_zero <= zero_s;
            out_tag  <= cy_q.tag;
        end else begin
            out_sum  <= out_sum;
            out_cout <= out_cout;
            out_ovf  <= out_ovf;
            out_zero <= out_zero;
            out_tag  <= out_tag;
        end
    end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Scoreboard bench: arithmetic reference model, queue of expected results, decoupled monitor.
module tb_pipelined_prefix_adder;
    localparam int W  = 64;
    localparam int TW = 4;
    localparam logic [11:0] SW_GS = {4'd2, 4'd1, 4'd4};
    localparam logic [11:0] SW_ST = {4'd2, 4'd3, 4'd1};

    logic          clk, rst_n;
    logic          in_valid, in_ready, in_cin, in_sub;
    logic [W-1:0]  in_a, in_b, out_sum;
    logic [TW-1:0] in_tag, out_tag;
    logic          out_valid, out_ready, out_cout, out_ovf, out_zero;

    logic          sw_valid;
    logic [31:0]   sw_a;
    logic [3:0]    sw_tag_in;
    logic [2:0]    sw_in_ready, sw_out_valid, sw_cout, sw_ovf, sw_zero;
    logic [31:0]   sw_sum [3];
    logic [3:0]    sw_tag [3];

    typedef struct {
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
        logic          zero;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   n_in = 0;
    int   n_out = 0;
    int   n_drop = 0;
    int   cyc = 0;
    bit   rand_rdy = 0;
    bit   rdy_val = 1;

    pipelined_prefix_adder #(.WIDTH(W), .GROUPSIZE(8), .STAGES(2), .TAG_W(TW)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero), .out_tag(out_tag)
    );

    for (genvar i = 0; i < 3; i++) begin : g_sw
        pipelined_prefix_adder #(
            .WIDTH(32), .GROUPSIZE(int'(SW_GS[i*4 +: 4])), .STAGES(int'(SW_ST[i*4 +: 4])), .TAG_W(4)
        ) u_sw (
            .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[i]),
            .in_a(sw_a), .in_b(32'd1), .in_cin(1'b0), .in_sub(1'b0), .in_tag(sw_tag_in),
            .out_valid(sw_out_valid[i]), .out_ready(1'b1), .out_sum(sw_sum[i]),
            .out_cout(sw_cout[i]), .out_ovf(sw_ovf[i]), .out_zero(sw_zero[i]), .out_tag(sw_tag[i])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference: plain wide arithmetic, signed range check for overflow, unsigned compare for borrow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub, input logic [TW-1:0] tag);
        exp_t e;
        logic [W:0] u;
        logic signed [W+1:0] sx;
        if (sub) begin
            u      = {1'b0, a} - {1'b0, b};
            e.cout = (a >= b);
            sx     = $signed({a[W-1], a[W-1], a}) - $signed({b[W-1], b[W-1], b});
        end else begin
            u      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            e.cout = u[W];
            sx     = $signed({a[W-1], a[W-1], a}) + $signed({b[W-1], b[W-1], b}) + $signed({{(W+1){1'b0}}, cin});
        end
        e.sum  = u[W-1:0];
        e.ovf  = (sx != $signed({u[W-1], u[W-1], u[W-1:0]}));
        e.zero = (e.sum == '0);
        e.tag  = tag;
        return e;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return {W{1'b1}};
            1:       return {1'b1, {(W-1){1'b0}}};
            2:       return {1'b0, {(W-1){1'b1}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Monitor: every output transfer is popped from the scoreboard and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: out_valid=1 tag=%h, required no pending result", out_tag);
                end else begin
                    e = sb_q.pop_front();
                    check("out_sum", out_sum, e.sum);
                    check("out_cout", W'(out_cout), W'(e.cout));
                    check("out_ovf", W'(out_ovf), W'(e.ovf));
                    check("out_zero", W'(out_zero), W'(e.zero));
                    check("out_tag", W'(out_tag), W'(e.tag));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic [TW-1:0] tag);
        bit done;
        done     = 1'b0;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_tag   = tag;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(model(a, b, cin, sub, tag));
                n_in++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300 && sb_q.size() != 0; n++) tick(1);
        check("drain_pending", W'(sb_q.size()), W'(0));
    endtask

    initial begin
        int c_start;
        int lat;
        int swlat[3];
        logic [32:0] u33;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0;
        sw_valid = 1'b0; sw_a = '0; sw_tag_in = '0;
        tick(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_sum", out_sum, '0);
        check("rst_flags", W'({out_cout, out_ovf, out_zero}), W'(0));
        check("rst_out_tag", W'(out_tag), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        tick(1);

        // Directed carry ripple and subtract corners.
        send({W{1'b1}}, '0, 1'b1, 1'b0, 4'd1);
        send({1'b1, {(W-1){1'b0}}}, 64'd1, 1'b0, 1'b1, 4'd2);
        send(64'd5, 64'd7, 1'b1, 1'b1, 4'd3);
        wait_drain();

        // Back-to-back stream, one accept per cycle.
        c_start = cyc;
        for (int t = 0; t < 16; t++) send(rand_op(), rand_op(), 1'($urandom), 1'($urandom), 4'(t));
        check("stream_cycles", W'(cyc - c_start), W'(16));
        wait_drain();

        // Stall with two results in flight.
        rdy_val = 1'b0;
        tick(1);
        send(rand_op(), rand_op(), 1'b0, 1'b0, 4'd10);
        send(rand_op(), rand_op(), 1'b1, 1'b1, 4'd11);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("stall_in_ready", W'(in_ready), W'(0));
            check("stall_out_valid", W'(out_valid), W'(1));
            check("stall_out_sum", out_sum, sb_q[0].sum);
            check("stall_out_tag", W'(out_tag), W'(sb_q[0].tag));
            tick(1);
        end
        rdy_val = 1'b1;
        wait_drain();

        // Reset with two results in flight: both dropped.
        rdy_val = 1'b0;
        tick(1);
        send(64'd100, 64'd23, 1'b0, 1'b0, 4'd12);
        send(64'd7, 64'd9, 1'b0, 1'b1, 4'd13);
        rst_n = 1'b0;
        n_drop += sb_q.size();
        sb_q.delete();
        tick(1);
        rst_n = 1'b1;
        rdy_val = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("post_rst_out_valid", W'(out_valid), W'(0));
            tick(1);
        end
        check("post_rst_out_sum", out_sum, '0);
        check("post_rst_flags_tag", W'({out_cout, out_ovf, out_zero, out_tag}), W'(0));

        // Latency of the first op after reset.
        in_a = 64'h1234; in_b = 64'h0F0F; in_cin = 1'b1; in_sub = 1'b0; in_tag = 4'd14; in_valid = 1'b1;
        @(negedge clk);
        check("lat_in_ready", W'(in_ready), W'(1));
        sb_q.push_back(model(64'h1234, 64'h0F0F, 1'b1, 1'b0, 4'd14));
        n_in++;
        lat = 0;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) in_valid = 1'b0;
            if (out_valid && lat == 0) lat = n;
        end
        check("latency", W'(lat), W'(2));
        wait_drain();

        // Random traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int t = 0; t < 40; t++) send(rand_op(), rand_op(), 1'($urandom), 1'($urandom), 4'($urandom));
        rand_rdy = 1'b0;
        wait_drain();

        // Other configurations: carry-chain vectors A = 2^k-1, B = 1, latency equals STAGES.
        for (int k = 0; k <= 32; k++) begin
            sw_a      = 32'((64'd1 << k) - 64'd1);
            sw_tag_in = 4'(k);
            u33       = {1'b0, sw_a} + 33'd1;
            check($sformatf("sw_in_ready_k%0d", k), W'(sw_in_ready), W'(3'b111));
            sw_valid  = 1'b1;
            swlat     = '{0, 0, 0};
            for (int n = 1; n <= 5; n++) begin
                @(posedge clk);
                #1;
                if (n == 1) sw_valid = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    if (sw_out_valid[i] && swlat[i] == 0) begin
                        swlat[i] = n;
                        check($sformatf("sw%0d_sum_k%0d", i, k), W'(sw_sum[i]), W'(u33[31:0]));
                        check($sformatf("sw%0d_cout_k%0d", i, k), W'(sw_cout[i]), W'(u33[32]));
                        check($sformatf("sw%0d_ovf_k%0d", i, k), W'(sw_ovf[i]), W'(sw_a == 32'h7FFF_FFFF));
                        check($sformatf("sw%0d_zero_k%0d", i, k), W'(sw_zero[i]), W'(u33[31:0] == 32'd0));
                        check($sformatf("sw%0d_tag_k%0d", i, k), W'(sw_tag[i]), W'(k % 16));
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                check($sformatf("sw%0d_latency_k%0d", i, k), W'(swlat[i]), W'(SW_ST[i*4 +: 4]));
            end
        end

        check("result_count", W'(n_out), W'(n_in - n_drop));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
